// File: rtl/mcycle_unit.sv
// Iterative multiply/divide unit: shift-add multiply and restoring divide, one result bit per cycle.
// Optional signed operation is enabled by defining MCYCLE_SIGNED_EN (adds the SignedOp input).
module mcycle_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             CLK,
    input  logic             RESETn,
    input  logic             Start,
    input  logic             MCycleOp,
`ifdef MCYCLE_SIGNED_EN
    input  logic             SignedOp,
`endif
    input  logic [WIDTH-1:0] Operand1,
    input  logic [WIDTH-1:0] Operand2,
    output logic [WIDTH-1:0] Result1,
    output logic [WIDTH-1:0] Result2,
    output logic             Busy
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        COMPUTING = 2'd1,
        DONE      = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             op_q, op_d;
    logic [WIDTH-1:0] fix_q, fix_d;   // multiplicand (MUL) or divisor (DIV)
    logic [WIDTH-1:0] shf_q, shf_d;   // multiplier / product low (MUL) or dividend / quotient (DIV)
    logic [WIDTH-1:0] acc_q, acc_d;   // product high (MUL) or partial remainder (DIV)
    logic [WIDTH-1:0] res1_q, res1_d;
    logic [WIDTH-1:0] res2_q, res2_d;

    logic [WIDTH-1:0] mag1, mag2;
    logic [WIDTH-1:0] fin1, fin2;

    // Multiply step: conditional add into the upper half, then shift the whole accumulator right
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH-1:0] mul_hi, mul_lo;
    assign mul_sum = {1'b0, acc_q} + (shf_q[0] ? {1'b0, fix_q} : {(WIDTH+1){1'b0}});
    assign mul_hi  = mul_sum[WIDTH:1];
    assign mul_lo  = {mul_sum[0], shf_q[WIDTH-1:1]};

    // Restoring divide step: borrow out of the extended subtract means "restore"
    logic [WIDTH:0]   div_shift;
    logic [WIDTH+1:0] div_diff;
    logic             div_ok;
    logic             div_unused;
    logic [WIDTH-1:0] div_rem, div_quo;
    assign div_shift  = {acc_q, shf_q[WIDTH-1]};
    assign div_diff   = {1'b0, div_shift} - {2'b00, fix_q};
    assign div_ok     = ~div_diff[WIDTH+1];
    assign div_unused = div_diff[WIDTH];
    assign div_rem    = div_ok ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
    assign div_quo    = {shf_q[WIDTH-2:0], div_ok};

    logic [WIDTH-1:0] iter_hi, iter_lo;
    assign iter_hi = op_q ? div_rem : mul_hi;
    assign iter_lo = op_q ? div_quo : mul_lo;

`ifdef MCYCLE_SIGNED_EN
    logic               neg1, neg2;
    logic               neg_lo_q, neg_lo_d;
    logic               neg_hi_q, neg_hi_d;
    logic               div0_q, div0_d;
    logic [2*WIDTH-1:0] prod, prod_neg;

    assign neg1     = SignedOp & Operand1[WIDTH-1];
    assign neg2     = SignedOp & Operand2[WIDTH-1];
    assign mag1     = neg1 ? ({WIDTH{1'b0}} - Operand1) : Operand1;
    assign mag2     = neg2 ? ({WIDTH{1'b0}} - Operand2) : Operand2;
    assign prod     = {iter_hi, iter_lo};
    assign prod_neg = {(2*WIDTH){1'b0}} - prod;

    // Sign fix-up happens on the same edge the raw result is captured
    always_comb begin
        if (!op_q) begin
            {fin2, fin1} = neg_lo_q ? prod_neg : prod;
        end else begin
            fin1 = div0_q   ? {WIDTH{1'b1}} : (neg_lo_q ? ({WIDTH{1'b0}} - iter_lo) : iter_lo);
            fin2 = neg_hi_q ? ({WIDTH{1'b0}} - iter_hi) : iter_hi;
        end
    end

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
            div0_q   <= 1'b0;
        end else begin
            neg_lo_q <= neg_lo_d;
            neg_hi_q <= neg_hi_d;
            div0_q   <= div0_d;
        end
    end

    always_comb begin
        neg_lo_d = neg_lo_q;
        neg_hi_d = neg_hi_q;
        div0_d   = div0_q;
        if (state_q == IDLE && Start) begin
            neg_lo_d = neg1 ^ neg2;
            neg_hi_d = neg1;
            div0_d   = (Operand2 == {WIDTH{1'b0}});
        end
    end
`else
    // Unsigned divide by zero naturally yields all-ones quotient and the dividend as remainder
    assign mag1 = Operand1;
    assign mag2 = Operand2;
    assign fin1 = iter_lo;
    assign fin2 = iter_hi;
`endif

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_q    <= 1'b0;
            fix_q   <= '0;
            shf_q   <= '0;
            acc_q   <= '0;
            res1_q  <= '0;
            res2_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            fix_q   <= fix_d;
            shf_q   <= shf_d;
            acc_q   <= acc_d;
            res1_q  <= res1_d;
            res2_q  <= res2_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        fix_d   = fix_q;
        shf_d   = shf_q;
        acc_d   = acc_q;
        res1_d  = res1_q;
        res2_d  = res2_q;
        Busy    = 1'b0;
        case (state_q)
            IDLE: begin
                Busy = Start;
                if (Start) begin
                    op_d    = MCycleOp;
                    fix_d   = MCycleOp ? mag2 : mag1;
                    shf_d   = MCycleOp ? mag1 : mag2;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = COMPUTING;
                end
            end
            COMPUTING: begin
                Busy  = 1'b1;
                acc_d = iter_hi;
                shf_d = iter_lo;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH-1)) begin
                    res1_d  = fin1;
                    res2_d  = fin2;
                    state_d = DONE;
                end
            end
            DONE: begin
                // Start is still asserted by the completing instruction, so it is ignored here
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign Result1 = res1_q;
    assign Result2 = res2_q;

endmodule

// File: tb/tb_mcycle_unit.sv
// Directed self-checking bench for mcycle_unit; one task per scenario, one line per transaction.
module tb_mcycle_unit;
    localparam int W = 32;

    logic         CLK = 1'b0;
    logic         RESETn = 1'b0;
    logic         Start = 1'b0;
    logic         MCycleOp = 1'b0;
`ifdef MCYCLE_SIGNED_EN
    logic         SignedOp = 1'b0;
`endif
    logic [W-1:0] Operand1 = '0;
    logic [W-1:0] Operand2 = '0;
    logic [W-1:0] Result1, Result2;
    logic         Busy;

    int checks = 0;
    int failures = 0;

    always #5 CLK = ~CLK;

    mcycle_unit #(.WIDTH(W), .CNT_W(6)) dut (
        .CLK      (CLK),
        .RESETn   (RESETn),
        .Start    (Start),
        .MCycleOp (MCycleOp),
`ifdef MCYCLE_SIGNED_EN
        .SignedOp (SignedOp),
`endif
        .Operand1 (Operand1),
        .Operand2 (Operand2),
        .Result1  (Result1),
        .Result2  (Result2),
        .Busy     (Busy)
    );

    // Issue at a falling edge with IDLE state; returns at the DONE falling edge with Start still high
    task automatic do_op(input logic op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic sgn, output int bcnt);
        Start = 1'b1;
        MCycleOp = op;
        Operand1 = a;
        Operand2 = b;
`ifdef MCYCLE_SIGNED_EN
        SignedOp = sgn;
`else
        if (sgn) $display("note: signed request ignored in unsigned build");
`endif
        bcnt = 0;
        #1;
        while (Busy === 1'b1 && bcnt < 200) begin
            bcnt++;
            @(negedge CLK);
        end
        $display("op=%0d a=%h b=%h busy_cycles=%0d r1=%h r2=%h", op, a, b, bcnt, Result1, Result2);
    endtask

    task automatic release_start();
        Start = 1'b0;
        @(negedge CLK);
    endtask

    task automatic test_reset();
        RESETn = 1'b0;
        Start = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        checks++; if (Busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", Busy); end
        checks++; if (Result1 !== '0) begin failures++; $display("FAIL reset_r1: got %h expected 0", Result1); end
        checks++; if (Result2 !== '0) begin failures++; $display("FAIL reset_r2: got %h expected 0", Result2); end
        RESETn = 1'b1;
        @(negedge CLK);
        $display("reset released");
    endtask

    task automatic test_mul_basic();
        int n;
        do_op(1'b0, 32'd7, 32'd6, 1'b0, n);
        checks++; if (n != 33) begin failures++; $display("FAIL mul_basic_busy_cycles: got %0d expected 33", n); end
        checks++; if (Busy !== 1'b0) begin failures++; $display("FAIL mul_basic_busy_done: got %b expected 0", Busy); end
        checks++; if (Result1 !== 32'd42) begin failures++; $display("FAIL mul_basic_r1: got %h expected %h", Result1, 32'd42); end
        checks++; if (Result2 !== 32'd0) begin failures++; $display("FAIL mul_basic_r2: got %h expected 0", Result2); end
        release_start();
        checks++; if (Result1 !== 32'd42) begin failures++; $display("FAIL mul_basic_hold: got %h expected %h", Result1, 32'd42); end
    endtask

    task automatic test_mul_overflow();
        int n;
        do_op(1'b0, 32'hFFFF_FFFF, 32'd2, 1'b0, n);
        checks++; if (Result1 !== 32'hFFFF_FFFE) begin failures++; $display("FAIL mul_ovf_r1: got %h expected fffffffe", Result1); end
        checks++; if (Result2 !== 32'h0000_0001) begin failures++; $display("FAIL mul_ovf_r2: got %h expected 00000001", Result2); end
        release_start();
    endtask

    task automatic test_div_basic();
        int n;
        do_op(1'b1, 32'd100, 32'd7, 1'b0, n);
        checks++; if (n != 33) begin failures++; $display("FAIL div_basic_busy_cycles: got %0d expected 33", n); end
        checks++; if (Result1 !== 32'd14) begin failures++; $display("FAIL div_basic_q: got %h expected %h", Result1, 32'd14); end
        checks++; if (Result2 !== 32'd2) begin failures++; $display("FAIL div_basic_r: got %h expected %h", Result2, 32'd2); end
        release_start();
    endtask

    task automatic test_div_by_zero();
        int n;
        do_op(1'b1, 32'h0000_1234, 32'd0, 1'b0, n);
        checks++; if (n != 33) begin failures++; $display("FAIL div0_busy_cycles: got %0d expected 33", n); end
        checks++; if (Result1 !== 32'hFFFF_FFFF) begin failures++; $display("FAIL div0_q: got %h expected ffffffff", Result1); end
        checks++; if (Result2 !== 32'h0000_1234) begin failures++; $display("FAIL div0_r: got %h expected 00001234", Result2); end
        release_start();
    endtask

    task automatic test_reset_mid();
        int n;
        Start = 1'b1;
        MCycleOp = 1'b0;
        Operand1 = 32'h0000_FFFF;
        Operand2 = 32'h0000_FFFF;
        for (int i = 0; i < 11; i++) @(negedge CLK);
        #2;
        RESETn = 1'b0;
        Start = 1'b0;
        #1;
        checks++; if (Busy !== 1'b0) begin failures++; $display("FAIL rstmid_busy: got %b expected 0", Busy); end
        checks++; if (Result1 !== '0) begin failures++; $display("FAIL rstmid_r1: got %h expected 0", Result1); end
        checks++; if (Result2 !== '0) begin failures++; $display("FAIL rstmid_r2: got %h expected 0", Result2); end
        $display("reset asserted mid-operation");
        @(negedge CLK);
        RESETn = 1'b1;
        @(negedge CLK);
        do_op(1'b0, 32'd3, 32'd5, 1'b0, n);
        checks++; if (n != 33) begin failures++; $display("FAIL rstmid_restart_cycles: got %0d expected 33", n); end
        checks++; if (Result1 !== 32'd15) begin failures++; $display("FAIL rstmid_restart_r1: got %h expected %h", Result1, 32'd15); end
        checks++; if (Result2 !== 32'd0) begin failures++; $display("FAIL rstmid_restart_r2: got %h expected 0", Result2); end
        release_start();
    endtask

    task automatic test_back_to_back();
        int n;
        do_op(1'b1, 32'd100, 32'd7, 1'b0, n);
        checks++; if (Result1 !== 32'd14) begin failures++; $display("FAIL b2b_first_q: got %h expected %h", Result1, 32'd14); end
        // Start stays high through DONE with the next instruction's operands already present
        Operand1 = 32'd9;
        Operand2 = 32'd3;
        @(negedge CLK);
        checks++; if (Busy !== 1'b1) begin failures++; $display("FAIL b2b_reaccept_busy: got %b expected 1", Busy); end
        checks++; if (Result1 !== 32'd14) begin failures++; $display("FAIL b2b_hold_q: got %h expected %h", Result1, 32'd14); end
        checks++; if (Result2 !== 32'd2) begin failures++; $display("FAIL b2b_hold_r: got %h expected %h", Result2, 32'd2); end
        do_op(1'b1, 32'd9, 32'd3, 1'b0, n);
        checks++; if (n != 33) begin failures++; $display("FAIL b2b_second_cycles: got %0d expected 33", n); end
        checks++; if (Result1 !== 32'd3) begin failures++; $display("FAIL b2b_second_q: got %h expected %h", Result1, 32'd3); end
        checks++; if (Result2 !== 32'd0) begin failures++; $display("FAIL b2b_second_r: got %h expected 0", Result2); end
        release_start();
    endtask

`ifdef MCYCLE_SIGNED_EN
    task automatic test_signed();
        int n;
        do_op(1'b0, 32'hFFFF_FFF9, 32'd3, 1'b1, n);
        checks++; if (Result1 !== 32'hFFFF_FFEB) begin failures++; $display("FAIL smul_lo: got %h expected ffffffeb", Result1); end
        checks++; if (Result2 !== 32'hFFFF_FFFF) begin failures++; $display("FAIL smul_hi: got %h expected ffffffff", Result2); end
        release_start();
        do_op(1'b1, 32'hFFFF_FFF9, 32'd2, 1'b1, n);
        checks++; if (Result1 !== 32'hFFFF_FFFD) begin failures++; $display("FAIL sdiv_q: got %h expected fffffffd", Result1); end
        checks++; if (Result2 !== 32'hFFFF_FFFF) begin failures++; $display("FAIL sdiv_r: got %h expected ffffffff", Result2); end
        release_start();
        do_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, n);
        checks++; if (Result1 !== 32'h8000_0000) begin failures++; $display("FAIL sdiv_minneg_q: got %h expected 80000000", Result1); end
        checks++; if (Result2 !== 32'd0) begin failures++; $display("FAIL sdiv_minneg_r: got %h expected 0", Result2); end
        release_start();
        do_op(1'b1, 32'hFFFF_FFF9, 32'd0, 1'b1, n);
        checks++; if (Result1 !== 32'hFFFF_FFFF) begin failures++; $display("FAIL sdiv0_q: got %h expected ffffffff", Result1); end
        checks++; if (Result2 !== 32'hFFFF_FFF9) begin failures++; $display("FAIL sdiv0_r: got %h expected fffffff9", Result2); end
        release_start();
    endtask
`endif

    initial begin
        test_reset();
        test_mul_basic();
        test_mul_overflow();
        test_div_basic();
        test_div_by_zero();
        test_reset_mid();
        test_back_to_back();
`ifdef MCYCLE_SIGNED_EN
        test_signed();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mcycle_unit.md
Name: mcycle_unit

Overview:
- Iterative multi-cycle multiply/divide unit in the execute stage, directly downstream of the instruction decoder.
- Consumes the decoder's Start and MCycleOp (0 = MUL, 1 = DIV) plus two register operands.
- Returns two result words and a Busy stall signal; the datapath holds the issuing instruction until Busy falls.
- One result bit per cycle: shift-add multiply, restoring divide.

Parameters:
- WIDTH, 32, operand width in bits; results are WIDTH each.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- CLK  in  1  rising-edge clock
- RESETn  in  1  asynchronous active-low reset
- Start  in  1  request from decoder (MUL or DIV instruction in execute)
- MCycleOp  in  1  0 = multiply, 1 = divide
- Operand1  in  WIDTH  multiplicand / dividend
- Operand2  in  WIDTH  multiplier / divisor
- Result1  out  WIDTH  MUL: product[WIDTH-1:0]; DIV: quotient
- Result2  out  WIDTH  MUL: product[2*WIDTH-1:WIDTH]; DIV: remainder
- Busy  out  1  stall request to the pipeline

Behaviour:
- Clock and reset are fixed: one clock, CLK; reset is asynchronous and active-low, RESETn.
- Reset values: state IDLE, counter 0, Result1 = 0, Result2 = 0, Busy = 0, internal shift registers 0.
- FSM states: IDLE, COMPUTING, DONE.
- IDLE:
  - Busy = Start, combinational, so the stall applies in the issue cycle.
  - On a CLK edge with Start = 1: latch Operand1, Operand2 and MCycleOp; clear the counter; go to COMPUTING.
  - Start = 0: remain in IDLE.
- COMPUTING:
  - Busy = 1.
  - One iteration per edge; the counter increments each edge.
  - Start, operands and MCycleOp are ignored; only latched copies are used.
  - On the edge where the counter equals WIDTH-1, load Result1/Result2 and go to DONE.
- DONE:
  - Busy = 0; results are stable.
  - Start is ignored, because the same instruction still drives Start this cycle.
  - Next edge goes to IDLE.
- Total Busy high time: WIDTH+1 cycles (issue cycle plus WIDTH computing cycles).
- Results are valid from entry to DONE and hold until the next completion. They are never cleared by a new Start.
- Multiply (unsigned):
  - Per iteration, if multiplier LSB = 1, add the multiplicand to the upper half of a 2*WIDTH accumulator with carry-out kept.
  - Shift the accumulator and multiplier right by 1.
  - Exact 2*WIDTH-bit product, no overflow.
- Divide (unsigned restoring):
  - Per iteration, shift {remainder, dividend} left by 1.
  - Trial-subtract the divisor from the remainder using a WIDTH+1-bit subtract.
  - If non-negative, keep the difference and set quotient bit = 1; else restore and set quotient bit = 0.
- Divide by zero: Result1 = all ones, Result2 = Operand1. Same WIDTH+1 cycle latency; no exception.
- RESETn low mid-operation: the operation is abandoned immediately; all outputs return to reset values; no partial results are visible.

Optional Feature:
- Macro: MCYCLE_SIGNED_EN.
- Defined:
  - Extra input port SignedOp (1 bit), sampled with Start.
  - When SignedOp = 1, operands are two's complement. Magnitudes are computed at latch time and fed to the unsigned core.
  - Product sign = XOR of the operand signs.
  - Quotient sign = XOR of the operand signs; remainder takes the dividend's sign.
  - Final negation is applied on the DONE transition, so latency is unchanged.
  - Signed divide by zero: Result1 = all ones, Result2 = Operand1.
  - Most-negative / -1: Result1 = most-negative, Result2 = 0.
- Undefined: no SignedOp port; all operations are unsigned.

Test Plan:
- Multiply, basic: MUL 7 x 6 -> Busy high 33 cycles, Result1 = 42, Result2 = 0, Busy low in DONE.
- Multiply, overflow into high word: MUL 0xFFFFFFFF x 2 -> Result1 = 0xFFFFFFFE, Result2 = 0x00000001.
- Divide, basic: DIV 100 / 7 -> Result1 = 14, Result2 = 2. Divide by zero: DIV 0x1234 / 0 -> Result1 = 0xFFFFFFFF, Result2 = 0x1234.
- Start held continuously through DONE -> exactly one operation completes; IDLE re-accepts on the following cycle; a second DIV 9 / 3 -> Result1 = 3, Result2 = 0.
- Reset mid-operation: RESETn low at computing cycle 10 -> Busy = 0 and Result1 = Result2 = 0 asynchronously. Restarting MUL 3 x 5 after reset -> Result1 = 15.
- Signed (MCYCLE_SIGNED_EN, SignedOp = 1): -7 x 3 -> Result1 = 0xFFFFFFEB, Result2 = 0xFFFFFFFF; -7 / 2 -> Result1 = 0xFFFFFFFD, Result2 = 0xFFFFFFFF.
